// File: rtl/zscore_trader.sv
// Rolling-window Z-score trader: mean/variance over 2^LOG2_WIN prices, iterative sqrt and divide, entry/exit position FSM.
// Latency 2*DATA_W+Z_FRAC+2 cycles per sample; in_ready is low from acceptance through DECIDE, so one sample is in flight.
module zscore_trader #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 4,
    parameter int Z_FRAC   = 8,
    parameter int Z_ENTRY  = 230,
    parameter int Z_EXIT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_price,
    output logic                     out_valid,
    output logic [DATA_W+Z_FRAC-1:0] z_score,
    output logic                     buy_signal,
    output logic                     sell_signal,
    output logic [1:0]               position,
    output logic                     warm
);

    localparam int N    = 1 << LOG2_WIN;
    localparam int ZW   = DATA_W + Z_FRAC;
    localparam int SW   = DATA_W + LOG2_WIN;
    localparam int QW   = 2 * DATA_W + LOG2_WIN;
    localparam int VW   = 2 * DATA_W;
    localparam int CNTW = LOG2_WIN + 1;
    localparam int CW   = $clog2(ZW + 1);

    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(N);
    localparam logic [ZW-1:0]   ENTRY_T   = ZW'(Z_ENTRY);
    localparam logic [ZW-1:0]   EXIT_T    = ZW'(Z_EXIT);
    localparam logic [CW-1:0]   SQRT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]   DIV_LAST  = CW'(ZW - 1);

    typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_SQRT, S_DIV, S_DECIDE} state_t;
    typedef enum logic [1:0] {P_FLAT = 2'b00, P_LONG = 2'b01, P_SHORT = 2'b10} pos_t;

    state_t              r_state, w_state_nxt;
    pos_t                r_pos, w_pos_nxt;
    logic [DATA_W-1:0]   r_price;
    logic [DATA_W-1:0]   r_buf [N];
    logic [LOG2_WIN-1:0] r_wptr;
    logic [CNTW-1:0]     r_cnt;
    logic [SW-1:0]       r_sum;
    logic [QW-1:0]       r_sqsum;
    logic [CW-1:0]       r_bit;
    logic [DATA_W-1:0]   r_srem;
    logic [DATA_W-1:0]   r_root;
    logic [DATA_W-1:0]   r_drem;
    logic [ZW-1:0]       r_quot;
    logic [ZW-1:0]       r_z;
    logic                r_warm;

    logic                w_full;
    logic [DATA_W-1:0]   w_old;
    logic [VW-1:0]       w_sq_new, w_sq_old;
    logic [SW-1:0]       w_sum_nxt;
    logic [QW-1:0]       w_sqsum_nxt;
    logic [DATA_W-1:0]   w_mean;
    logic [VW-1:0]       w_sqmean, w_mean_sq, w_var;
    logic [1:0]          w_pair;
    logic [DATA_W+1:0]   w_srem_sh, w_strial;
    logic [DATA_W-1:0]   w_srem_sub;
    logic                w_sge;
    logic [DATA_W-1:0]   w_delta;
    logic [ZW-1:0]       w_dividend;
    logic                w_dbit;
    logic [DATA_W:0]     w_drem_sh;
    logic [DATA_W-1:0]   w_drem_sub;
    logic                w_dge;
    logic [ZW-1:0]       w_z;
    logic                w_below, w_above, w_gt_entry, w_le_exit;
    logic                w_buy, w_sell;

    // Before the window fills, the slot being written holds stale data and must not be subtracted.
    assign w_full      = (r_cnt == CNT_FULL);
    assign w_old       = w_full ? r_buf[r_wptr] : '0;
    assign w_sq_new    = VW'(r_price) * VW'(r_price);
    assign w_sq_old    = VW'(w_old) * VW'(w_old);
    assign w_sum_nxt   = r_sum + SW'(r_price) - SW'(w_old);
    assign w_sqsum_nxt = r_sqsum + QW'(w_sq_new) - QW'(w_sq_old);

    assign w_mean    = r_sum[SW-1:LOG2_WIN];
    assign w_sqmean  = r_sqsum[QW-1:LOG2_WIN];
    assign w_mean_sq = VW'(w_mean) * VW'(w_mean);
    assign w_var     = (w_sqmean > w_mean_sq) ? (w_sqmean - w_mean_sq) : '0;

    always_comb begin
        w_pair = '0;
        w_dbit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_bit == CW'(i)) w_pair = w_var[2*i +: 2];
        end
        for (int i = 0; i < ZW; i++) begin
            if (r_bit == CW'(i)) w_dbit = w_dividend[i];
        end
    end

    // Restoring sqrt: the partial remainder fits DATA_W bits on every step but the last, which is discarded.
    assign w_srem_sh  = {r_srem, w_pair};
    assign w_strial   = {r_root, 2'b01};
    assign w_sge      = (w_srem_sh >= w_strial);
    assign w_srem_sub = w_srem_sh[DATA_W-1:0] - w_strial[DATA_W-1:0];

    assign w_delta    = (r_price >= w_mean) ? (r_price - w_mean) : (w_mean - r_price);
    assign w_dividend = {w_delta, {Z_FRAC{1'b0}}};
    assign w_drem_sh  = {r_drem, w_dbit};
    assign w_dge      = (w_drem_sh >= {1'b0, r_root});
    assign w_drem_sub = w_drem_sh[DATA_W-1:0] - r_root;
    assign w_z        = (r_root == '0) ? '0 : r_quot;

    assign w_below    = (r_price < w_mean);
    assign w_above    = (r_price > w_mean);
    assign w_gt_entry = (w_z > ENTRY_T);
    assign w_le_exit  = (w_z <= EXIT_T);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = S_SQRT;
            S_SQRT:   if (r_bit == '0) w_state_nxt = S_DIV;
            S_DIV:    if (r_bit == '0) w_state_nxt = S_DECIDE;
            S_DECIDE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Trading only starts once the window was already full before this sample.
    always_comb begin
        w_pos_nxt = r_pos;
        w_buy     = 1'b0;
        w_sell    = 1'b0;
        if (r_state == S_DECIDE && r_warm) begin
            case (r_pos)
                P_FLAT: begin
                    if (w_gt_entry && w_below) begin
                        w_pos_nxt = P_LONG;
                        w_buy     = 1'b1;
                    end else if (w_gt_entry && w_above) begin
                        w_pos_nxt = P_SHORT;
                        w_sell    = 1'b1;
                    end
                end
                P_LONG: begin
                    if (w_le_exit || !w_below) begin
                        w_pos_nxt = P_FLAT;
                        w_sell    = 1'b1;
                    end
                end
                P_SHORT: begin
                    if (w_le_exit || !w_above) begin
                        w_pos_nxt = P_FLAT;
                        w_buy     = 1'b1;
                    end
                end
                default: w_pos_nxt = P_FLAT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_UPDATE) r_buf[r_wptr] <= r_price;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_price <= '0;
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_sqsum <= '0;
            r_bit   <= '0;
            r_srem  <= '0;
            r_root  <= '0;
            r_drem  <= '0;
            r_quot  <= '0;
            r_z     <= '0;
            r_pos   <= P_FLAT;
            r_warm  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) r_price <= in_price;
                S_UPDATE: begin
                    r_sum   <= w_sum_nxt;
                    r_sqsum <= w_sqsum_nxt;
                    r_wptr  <= r_wptr + 1'b1;
                    if (!w_full) r_cnt <= r_cnt + 1'b1;
                    r_bit   <= SQRT_LAST;
                    r_srem  <= '0;
                    r_root  <= '0;
                    r_drem  <= '0;
                    r_quot  <= '0;
                end
                S_SQRT: begin
                    r_srem <= w_sge ? w_srem_sub : w_srem_sh[DATA_W-1:0];
                    r_root <= {r_root[DATA_W-2:0], w_sge};
                    r_bit  <= (r_bit == '0) ? DIV_LAST : r_bit - 1'b1;
                end
                S_DIV: begin
                    r_drem <= w_dge ? w_drem_sub : w_drem_sh[DATA_W-1:0];
                    r_quot <= {r_quot[ZW-2:0], w_dge};
                    r_bit  <= r_bit - 1'b1;
                end
                S_DECIDE: begin
                    r_z    <= w_z;
                    r_pos  <= w_pos_nxt;
                    r_warm <= r_warm | w_full;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign out_valid   = (r_state == S_DECIDE);
    assign z_score     = out_valid ? w_z : r_z;
    assign position    = out_valid ? w_pos_nxt : r_pos;
    assign warm        = r_warm | (out_valid & w_full);
    assign buy_signal  = w_buy;
    assign sell_signal = w_sell;

endmodule

// File: tb/tb_zscore_trader.sv
// Scoreboard bench for zscore_trader: a reference window model queues expected results per accepted price.
module tb_zscore_trader;

    localparam int DATA_W   = 8;
    localparam int LOG2_WIN = 4;
    localparam int Z_FRAC   = 8;
    localparam int ZW       = DATA_W + Z_FRAC;
    localparam int N        = 1 << LOG2_WIN;
    localparam int Z_ENTRY  = 230;
    localparam int Z_EXIT   = 64;
    localparam int L        = 2 * DATA_W + Z_FRAC + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_price = '0;
    logic              in_ready, out_valid, buy_signal, sell_signal, warm;
    logic [ZW-1:0]     z_score;
    logic [1:0]        position;

    zscore_trader #(
        .DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN), .Z_FRAC(Z_FRAC),
        .Z_ENTRY(Z_ENTRY), .Z_EXIT(Z_EXIT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_price(in_price), .out_valid(out_valid), .z_score(z_score),
        .buy_signal(buy_signal), .sell_signal(sell_signal),
        .position(position), .warm(warm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int z;
        int buy;
        int sell;
        int pos;
        int warm;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   m_win[N];
    int   m_cnt = 0;
    int   m_wptr = 0;
    int   m_pos = 0;
    int   hold_z = 0;
    bit   b2b = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_acc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
        end
    endtask

    // Reference: recompute the window sums from scratch and use brute-force sqrt and integer division.
    task automatic model(input int p);
        exp_t e;
        int sum, sq, mean, vr, sd, dl, z;
        bit was_warm;
        was_warm = (m_cnt == N);
        m_win[m_wptr] = p;
        m_wptr = (m_wptr + 1) % N;
        if (m_cnt < N) m_cnt++;
        sum = 0;
        sq  = 0;
        for (int i = 0; i < N; i++) begin
            if (i < m_cnt) begin
                sum += m_win[i];
                sq  += m_win[i] * m_win[i];
            end
        end
        mean = sum / N;
        vr = sq / N - mean * mean;
        if (vr < 0) vr = 0;
        sd = 0;
        while ((sd + 1) * (sd + 1) <= vr) sd++;
        dl = (p > mean) ? p - mean : mean - p;
        z  = (sd == 0) ? 0 : (dl * (1 << Z_FRAC)) / sd;
        e.buy  = 0;
        e.sell = 0;
        if (was_warm) begin
            case (m_pos)
                0: if (z > Z_ENTRY && p < mean) begin m_pos = 1; e.buy = 1; end
                   else if (z > Z_ENTRY && p > mean) begin m_pos = 2; e.sell = 1; end
                1: if (z <= Z_EXIT || p >= mean) begin m_pos = 0; e.sell = 1; end
                default: if (z <= Z_EXIT || p <= mean) begin m_pos = 0; e.buy = 1; end
            endcase
        end
        e.z    = z;
        e.pos  = m_pos;
        e.warm = (m_cnt == N) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic send(input int p);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            chk("ready_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_price = DATA_W'(p);
        model(p);
        @(posedge clk); #1;
        in_price = 8'hFF;
        in_valid = b2b;
    endtask

    task automatic load_window();
        for (int i = 0; i < 8; i++) begin
            send(96);
            send(104);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        acc_q.delete();
        hold_z = 0;
        have_prev = 1'b0;
        m_cnt = 0;
        m_wptr = 0;
        m_pos = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z_score", z_score, 0);
        chk("rst_position", position, 0);
        chk("rst_warm", warm, 0);
        chk("rst_buy", buy_signal, 0);
        chk("rst_sell", sell_signal, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);
        repeat (L + 4) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        int a;
        if (!rst) begin
            if (in_valid && in_ready) begin
                if (b2b) begin
                    if (have_prev) chk("acc_gap", cyc - prev_acc, L + 1);
                    prev_acc  = cyc;
                    have_prev = 1'b1;
                end
                acc_q.push_back(cyc);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("stray_out_valid", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                    chk("latency", cyc - a, L);
                    chk("z_score", z_score, e.z);
                    chk("buy", buy_signal, e.buy);
                    chk("sell", sell_signal, e.sell);
                    chk("position", position, e.pos);
                    chk("warm", warm, e.warm);
                    hold_z = e.z;
                end
            end else begin
                if (buy_signal || sell_signal) chk("pulse_without_ov", {buy_signal, sell_signal}, 0);
                if (z_score !== ZW'(hold_z)) chk("z_hold", z_score, hold_z);
            end
            if (buy_signal && sell_signal) chk("buy_and_sell", 1, 0);
            if (position == 2'b11) chk("position_11", position, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int prices[6];
        prices = '{100, 110, 90, 100, 120, 80};

        do_reset();
        repeat (16) send(100);

        do_reset();
        load_window();
        send(90);

        do_reset();
        load_window();
        send(80);
        send(100);

        do_reset();
        load_window();
        send(120);
        send(90);

        // Abort a sample mid-divide while holding a LONG position.
        do_reset();
        load_window();
        send(80);
        send(100);
        repeat (14) @(posedge clk);
        do_reset();

        b2b = 1'b1;
        have_prev = 1'b0;
        foreach (prices[i]) send(prices[i]);
        b2b = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
